// File: rtl/fifo_pkg.sv
// Shared types and defaults for the single-clock FIFO controller and its consumers.
package fifo_pkg;

    localparam int DEF_DATA_WIDTH = 8;
    localparam int DEF_ADDR_SIZE  = 3;

    typedef struct packed {
        logic [DEF_ADDR_SIZE:0] count;
        logic                   almost_full;
        logic                   almost_empty;
        logic                   overflow;
        logic                   underflow;
    } fifo_status_t;

endpackage

// File: rtl/fifo_mem.sv
// FIFO storage: synchronous write, asynchronous read, contents survive reset.
module fifo_mem
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ADDR_SIZE  = DEF_ADDR_SIZE
) (
    input  logic                  clk,
    input  logic                  w_en,
    input  logic [ADDR_SIZE-1:0]  w_addr,
    input  logic [DATA_WIDTH-1:0] w_data,
    input  logic [ADDR_SIZE-1:0]  r_addr,
    output logic [DATA_WIDTH-1:0] r_data
);

    logic [DATA_WIDTH-1:0] mem [2**ADDR_SIZE];

    always_ff @(posedge clk) begin
        if (w_en) begin
            mem[w_addr] <= w_data;
        end
    end

    assign r_data = mem[r_addr];

endmodule

// File: rtl/fifo_sync_ctrl.sv
// Single-clock FIFO controller: pointers, occupancy flags, sticky error bits and
// valid/ready handshakes around a fifo_mem instance.
module fifo_sync_ctrl
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ADDR_SIZE  = DEF_ADDR_SIZE,
    parameter int AFULL_LVL  = 6,
    parameter int AEMPTY_LVL = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  w_valid,
    input  logic [DATA_WIDTH-1:0] w_data,
    output logic                  w_ready,
    output logic                  r_valid,
    output logic [DATA_WIDTH-1:0] r_data,
    input  logic                  r_ready,
    output logic [ADDR_SIZE:0]    count,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic                  overflow,
    output logic                  underflow,
    input  logic                  err_clr
);

    localparam int DEPTH = 2**ADDR_SIZE;
    localparam logic [ADDR_SIZE:0] AFULL_THR  = (ADDR_SIZE+1)'(AFULL_LVL);
    localparam logic [ADDR_SIZE:0] AEMPTY_THR = (ADDR_SIZE+1)'(AEMPTY_LVL);

    if (AFULL_LVL < 1 || AFULL_LVL > DEPTH || AEMPTY_LVL < 0 || AEMPTY_LVL >= DEPTH) begin : g_bad_lvl
        $error("fifo_sync_ctrl: AFULL_LVL must be 1..DEPTH and AEMPTY_LVL 0..DEPTH-1");
    end

    logic [ADDR_SIZE:0] w_ptr;
    logic [ADDR_SIZE:0] r_ptr;
    logic               full;
    logic               empty;
    logic               push;
    logic               pop;

    // The extra pointer bit distinguishes full from empty when the low bits match.
    assign empty = (w_ptr == r_ptr);
    assign full  = (w_ptr[ADDR_SIZE] != r_ptr[ADDR_SIZE]) &&
                   (w_ptr[ADDR_SIZE-1:0] == r_ptr[ADDR_SIZE-1:0]);

    assign w_ready      = !full;
    assign r_valid      = !empty;
    assign push         = w_valid && w_ready;
    assign pop          = r_valid && r_ready;
    assign count        = w_ptr - r_ptr;
    assign almost_full  = (count >= AFULL_THR);
    assign almost_empty = (count <= AEMPTY_THR);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            w_ptr     <= '0;
            r_ptr     <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (push) begin
                w_ptr <= w_ptr + 1'b1;
            end
            if (pop) begin
                r_ptr <= r_ptr + 1'b1;
            end
            // A fresh error outranks a clear arriving in the same cycle.
            if (w_valid && full) begin
                overflow <= 1'b1;
            end else if (err_clr) begin
                overflow <= 1'b0;
            end
            if (r_ready && empty) begin
                underflow <= 1'b1;
            end else if (err_clr) begin
                underflow <= 1'b0;
            end
        end
    end

    fifo_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_SIZE  (ADDR_SIZE)
    ) u_mem (
        .clk    (clk),
        .w_en   (push),
        .w_addr (w_ptr[ADDR_SIZE-1:0]),
        .w_data (w_data),
        .r_addr (r_ptr[ADDR_SIZE-1:0]),
        .r_data (r_data)
    );

endmodule

// File: tb/tb_fifo_sync_ctrl.sv
// Bench for fifo_sync_ctrl: directed sequences plus a random phase, checked against a queue model.
module tb_fifo_sync_ctrl;

    localparam int DW    = 8;
    localparam int AS    = 3;
    localparam int DEPTH = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          w_valid = 1'b0;
    logic [DW-1:0] w_data = '0;
    logic          w_ready;
    logic          r_valid;
    logic [DW-1:0] r_data;
    logic          r_ready = 1'b0;
    logic [AS:0]   count;
    logic          almost_full;
    logic          almost_empty;
    logic          overflow;
    logic          underflow;
    logic          err_clr = 1'b0;

    int checks = 0;
    int errors = 0;
    bit mon_en = 1'b0;

    logic [DW-1:0] exp_q[$];
    bit            m_ovf = 1'b0;
    bit            m_udf = 1'b0;

    fifo_sync_ctrl #(
        .DATA_WIDTH (DW),
        .ADDR_SIZE  (AS),
        .AFULL_LVL  (6),
        .AEMPTY_LVL (1)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .w_valid      (w_valid),
        .w_data       (w_data),
        .w_ready      (w_ready),
        .r_valid      (r_valid),
        .r_data       (r_data),
        .r_ready      (r_ready),
        .count        (count),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .overflow     (overflow),
        .underflow    (underflow),
        .err_clr      (err_clr)
    );

    always #5 clk = ~clk;

    // Scoreboard update: expected entries are queued as the stimulus is accepted.
    always @(posedge clk) begin
        bit do_push;
        bit do_pop;
        if (!rst_n) begin
            exp_q.delete();
            m_ovf = 1'b0;
            m_udf = 1'b0;
        end else begin
            do_push = w_valid && (exp_q.size() < DEPTH);
            do_pop  = r_ready && (exp_q.size() > 0);
            if (w_valid && exp_q.size() == DEPTH) m_ovf = 1'b1;
            else if (err_clr)                     m_ovf = 1'b0;
            if (r_ready && exp_q.size() == 0)     m_udf = 1'b1;
            else if (err_clr)                     m_udf = 1'b0;
            if (do_pop)  void'(exp_q.pop_front());
            if (do_push) exp_q.push_back(w_data);
        end
    end

    task automatic cmp(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: compares every presented output against the scoreboard away from the edge.
    always @(negedge clk) begin
        if (mon_en) begin
            cmp("mon_count", int'(count), exp_q.size());
            cmp("mon_w_ready", int'(w_ready), int'(exp_q.size() < DEPTH));
            cmp("mon_r_valid", int'(r_valid), int'(exp_q.size() > 0));
            cmp("mon_afull", int'(almost_full), int'(exp_q.size() >= 6));
            cmp("mon_aempty", int'(almost_empty), int'(exp_q.size() <= 1));
            cmp("mon_overflow", int'(overflow), int'(m_ovf));
            cmp("mon_underflow", int'(underflow), int'(m_udf));
            if (r_valid && exp_q.size() > 0)
                cmp("mon_r_data", int'(r_data), int'(exp_q[0]));
        end
    end

    task automatic cyc(input bit wv, input logic [DW-1:0] wd, input bit rr,
                       input bit ec, input bit rn);
        w_valid = wv;
        w_data  = wd;
        r_ready = rr;
        err_clr = ec;
        rst_n   = rn;
        @(posedge clk);
        #1;
        w_valid = 1'b0;
        r_ready = 1'b0;
        err_clr = 1'b0;
        rst_n   = 1'b1;
    endtask

    task automatic push_n(input int n, input logic [DW-1:0] base);
        for (int i = 0; i < n; i++) cyc(1'b1, base + DW'(i), 1'b0, 1'b0, 1'b1);
    endtask

    task automatic pop_n(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, '0, 1'b1, 1'b0, 1'b1);
    endtask

    initial begin
        cyc(1'b0, '0, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, '0, 1'b0, 1'b0, 1'b0);
        mon_en = 1'b1;
        cmp("rst_count", int'(count), 0);
        cmp("rst_w_ready", int'(w_ready), 1);
        cmp("rst_r_valid", int'(r_valid), 0);
        cmp("rst_aempty", int'(almost_empty), 1);

        // Fill 0x11..0x18 checking count and almost_full at every step, then drain.
        for (int i = 0; i < 8; i++) begin
            cyc(1'b1, 8'h11 + 8'(i), 1'b0, 1'b0, 1'b1);
            cmp("fill_count", int'(count), i + 1);
            cmp("fill_afull", int'(almost_full), int'(i + 1 >= 6));
        end
        cmp("full_w_ready", int'(w_ready), 0);
        cmp("full_head", int'(r_data), 'h11);
        pop_n(8);
        cmp("drain_count", int'(count), 0);
        cmp("drain_r_valid", int'(r_valid), 0);

        // Wrap both pointers past the top of the memory.
        push_n(8, 8'h11);
        pop_n(3);
        cmp("wrap_head", int'(r_data), 'h14);
        push_n(3, 8'hA0);
        cmp("wrap_count", int'(count), 8);
        pop_n(8);
        cmp("wrap_empty", int'(count), 0);

        // Steady-state simultaneous push and pop.
        push_n(4, 8'h30);
        for (int i = 0; i < 10; i++) begin
            cyc(1'b1, 8'h40 + 8'(i), 1'b1, 1'b0, 1'b1);
            cmp("stream_count", int'(count), 4);
        end
        cmp("stream_head", int'(r_data), 'h46);
        pop_n(4);

        // Error flags: overflow, underflow, clear racing a new error, plain clear.
        push_n(8, 8'h60);
        cyc(1'b1, 8'hEE, 1'b0, 1'b0, 1'b1);
        cmp("ovf_set", int'(overflow), 1);
        cmp("ovf_count", int'(count), 8);
        pop_n(8);
        cyc(1'b0, '0, 1'b1, 1'b0, 1'b1);
        cmp("udf_set", int'(underflow), 1);
        push_n(8, 8'h70);
        cyc(1'b1, 8'hEF, 1'b0, 1'b1, 1'b1);
        cmp("clr_race_ovf", int'(overflow), 1);
        cmp("clr_race_udf", int'(underflow), 0);
        cyc(1'b0, '0, 1'b0, 1'b1, 1'b1);
        cmp("clr_ovf", int'(overflow), 0);
        cmp("clr_udf", int'(underflow), 0);
        pop_n(8);

        // Reset mid-transfer wins over push and pop.
        push_n(5, 8'h80);
        cyc(1'b1, 8'h99, 1'b1, 1'b0, 1'b0);
        cmp("mid_rst_count", int'(count), 0);
        cmp("mid_rst_r_valid", int'(r_valid), 0);
        cmp("mid_rst_w_ready", int'(w_ready), 1);
        cyc(1'b1, 8'h5A, 1'b0, 1'b0, 1'b1);
        cmp("post_rst_data", int'(r_data), 'h5A);
        cmp("post_rst_count", int'(count), 1);
        pop_n(1);

        // Random traffic against the scoreboard.
        for (int i = 0; i < 10000; i++) begin
            cyc(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)),
                ($urandom_range(0, 31) == 0), 1'b1);
        end

        mon_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
